// File: rtl/factorial_engine.sv
// factorial_engine
//   Iterative factorial unit: accepts an operand n over a valid/ready input
//   handshake, performs one multiply per cycle (n * (n-1) * ... * 2) and
//   presents n! on a valid/ready output handshake with backpressure.
//   A sticky overflow flag reports when the true n! did not fit in OUT_W bits.
//
//   Optional build macro: FACTORIAL_ENGINE_SATURATE_EN
//     defined   -> an overflowing result is reported as all ones
//     undefined -> an overflowing result is reported as the wrapped low bits
//
// Parameters
//   IN_W   operand width (n in 0 .. 2^IN_W-1)
//   OUT_W  result width
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   request valid
//   in_ready   engine accepts a request this cycle
//   in_data    operand n
//   out_valid  result valid, held until taken
//   out_ready  consumer takes the result
//   out_data   n! (wrapped or saturated)
//   out_ovf    true n! did not fit in OUT_W bits
//   out_busy   multiply iterations in progress
module factorial_engine #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 46
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                  state_q;
  logic [OUT_W-1:0]        acc_q;
  logic [IN_W-1:0]         cnt_q;
  logic                    ovf_q;
  logic                    out_valid_q;
  logic [OUT_W-1:0]        out_data_q;
  logic                    out_ovf_q;
  logic                    out_busy_q;

  logic [OUT_W+IN_W-1:0]   prod_d;
  logic [OUT_W-1:0]        prod_lo_d;
  logic                    ovf_d;
  logic [OUT_W-1:0]        result_d;
  logic                    start_calc_d;
  logic                    last_calc_d;

`ifdef FACTORIAL_ENGINE_SATURATE_EN
  function automatic logic [OUT_W-1:0] sat_result(input logic [OUT_W-1:0] val,
                                                  input logic             ovf);
    sat_result = ovf ? {OUT_W{1'b1}} : val;
  endfunction
`endif

  // Full-width product so that any bit lost above OUT_W is visible to the
  // overflow flag; the accumulator keeps only the low bits (n! mod 2^OUT_W).
  assign prod_d    = {{IN_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, cnt_q};
  assign prod_lo_d = prod_d[OUT_W-1:0];
  assign ovf_d     = ovf_q | (prod_d[OUT_W+IN_W-1:OUT_W] != '0);

`ifdef FACTORIAL_ENGINE_SATURATE_EN
  assign result_d  = sat_result(prod_lo_d, ovf_d);
`else
  assign result_d  = prod_lo_d;
`endif

  // Extended compares keep the constants representable for any IN_W.
  assign start_calc_d = ({1'b0, in_data} > (IN_W+1)'(1));
  assign last_calc_d  = ({1'b0, cnt_q} == (IN_W+1)'(2));

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_busy  = out_busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= {{(OUT_W-1){1'b0}}, 1'b1};
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_q <= {{(OUT_W-1){1'b0}}, 1'b1};
            cnt_q <= in_data;
            ovf_q <= 1'b0;
            if (start_calc_d) begin
              state_q    <= S_CALC;
              out_busy_q <= 1'b1;
            end else begin
              // 0! and 1! need no multiply: the result is ready at once.
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= {{(OUT_W-1){1'b0}}, 1'b1};
              out_ovf_q   <= 1'b0;
            end
          end
        end
        S_CALC: begin
          acc_q <= prod_lo_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - 1'b1;
          if (last_calc_d) begin
            state_q     <= S_DONE;
            out_busy_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= result_d;
            out_ovf_q   <= ovf_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/factorial_engine.md
Name: factorial_engine

Overview:
Parametrised iterative factorial unit, successor to the fixed 4-bit/46-bit factorial block.
- Generic operand and result widths.
- valid/ready handshakes on both input and output, with output backpressure.
- Correct handling of 0! and 1!.
- Sticky overflow detection.
- Sits between a request producer and a result consumer in the math datapath; one multiply per cycle.

Parameters:
IN_W, 4, operand width; n ranges 0 .. 2^IN_W-1
OUT_W, 46, result width; default holds 15! without overflow

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  engine accepts request this cycle
in_data  input  IN_W  operand n
out_valid  output  1  result valid, held until taken
out_ready  input  1  consumer takes result
out_data  output  OUT_W  n! (low OUT_W bits, or saturated)
out_ovf  output  1  true n! did not fit in OUT_W bits
out_busy  output  1  multiply iterations in progress (CALC state)

Behaviour:
- States: IDLE, CALC, DONE. Reset (sampled at clk edge) forces IDLE from any state, including mid-CALC and DONE; an in-flight result is discarded.
- Reset values: out_valid=0, out_busy=0, out_ovf=0, out_data=0. Internal registers: acc=1, cnt=0.
- in_ready = (state==IDLE) && !reset. in_ready=0 in CALC and DONE.
- Accept: edge with IDLE && in_valid && in_ready.
  - acc<=1, cnt<=in_data, ovf<=0.
  - Next state is CALC if in_data>=2, else DONE.
- CALC, each cycle:
  - Full product p = acc*cnt, width OUT_W+IN_W.
  - acc<=p[OUT_W-1:0].
  - ovf<=ovf | (p[OUT_W+IN_W-1:OUT_W]!=0); the flag is sticky.
  - cnt<=cnt-1.
  - When cnt==2 this cycle, next state is DONE.
  - CALC therefore lasts exactly n-1 cycles (multiplies by n..2).
- Latency: out_valid rises max(n-1,0) edges after the accept edge. For n=0 and n=1 it is high in the cycle right after acceptance, with out_data=1.
- DONE:
  - out_valid=1; out_data=acc (or saturated, see Optional Feature); out_ovf=ovf.
  - All three held stable until an edge with out_ready=1, then next state is IDLE.
  - out_valid=0 in the following cycle.
- out_ready is ignored outside DONE. in_valid/in_data are ignored outside IDLE; no queuing.
- Back-to-back requests: minimum one IDLE cycle between results.
- out_busy = (state==CALC).
- Wrapped out_data always equals the true n! mod 2^OUT_W.

Optional Feature:
Macro FACTORIAL_ENGINE_SATURATE_EN.
- Defined: when ovf=1 in DONE, out_data = all ones (2^OUT_W-1); out_ovf still asserted.
- Undefined: out_data is the wrapped low OUT_W bits; out_ovf still asserted.
- Non-overflowing results are identical in both builds.

Test Plan:
- Defaults, n=5, out_ready=1 -> accept, out_busy high 4 cycles, out_valid 4 edges after accept, out_data=120, out_ovf=0; in_ready returns 1 the cycle after the result is taken.
- n=0 then n=1 -> each gives out_data=1, out_ovf=0, out_valid in the cycle after accept, out_busy never high.
- Defaults, n=15 -> out_data=1307674368000, out_ovf=0, 14 CALC cycles.
- OUT_W=16, n=8 -> out_data=0x9D80, ovf=0.
- OUT_W=16, n=9 -> ovf=1; out_data=0x8980 without macro, 0xFFFF with FACTORIAL_ENGINE_SATURATE_EN.
- Backpressure and reset:
  - n=4 with out_ready=0 for 10 cycles -> out_valid/out_data=24 held stable, in_ready=0, in_valid pulses ignored.
  - Separately, reset asserted for 1 cycle mid-CALC of n=7 -> IDLE, all outputs 0, in_ready=1 next cycle; a following n=3 yields 6.
